song_draw_control: RTL
======================

Name: song_draw_control

Overview:
- Control FSM directly upstream of the note-lane datapath; generates every strobe and counter that datapath consumes.
- Sequence: clear the 240x180 play grid, then once per step tick: shift the song, redraw all 12 note boxes, score the step.
- Asserts songDone after SONG_STEPS steps and returns to idle.
- Also produces the VGA adapter write-enable (plot), time-aligned to the datapath's registered X/Y/colour outputs.

Parameters:
- TICKS_PER_STEP, 833334: clock cycles between song steps (~60 Hz at 50 MHz).
- SONG_STEPS, 112: shifts per song (length of note shift registers minus 3-bit lookahead).
- GRID_W, 240: cleared region width in pixels.
- GRID_H, 180: cleared region height in pixels.
- BOX_W, 60: note box width.
- BOX_H, 60: note box height.
- PLOT_LAT, 3: cycles from write strobe to valid datapath VGA outputs.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; begins a song when sampled high in IDLE.
- shiftSong  output  1  one-cycle song shift strobe.
- loadDefault  output  1  load default-pixel registers.
- writeDefault  output  1  select default (clear) pixel path.
- loadStartAddress  output  1  box start address valid.
- loadX  output  1  load box pixel address.
- loadY  output  1  load box pixel address (driven identical to loadX).
- writeToScreen  output  1  select box pixel path.
- changeScore  output  1  evaluate note hits.
- addScore  output  1  accumulate hit into score.
- songDone  output  1  one-cycle end-of-song strobe.
- gridCounter  output  16  {X[7:0], Y[7:0]} clear-sweep position.
- boxCounter  output  4  current box index, 1..12; 0 = none.
- pixelCount  output  15  {X[7:0], Y[6:0]} offset inside box.
- plot  output  1  VGA write enable.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all outputs, counters, tick divider, step counter and the plot delay line = 0.
- States and transitions:
  - IDLE: busy=0. start=1 -> CLEAR with gridCounter=0.
  - CLEAR: loadDefault=1, writeDefault=1 each cycle.
    - Y field increments 0..GRID_H-1; on wrap, Y clears and X increments.
    - At X=GRID_W-1, Y=GRID_H-1 -> TICK_WAIT with divider=0 and step=0.
    - Takes exactly GRID_W*GRID_H = 43200 cycles.
  - TICK_WAIT: divider counts up; at TICKS_PER_STEP-1 -> SHIFT.
  - SHIFT: shiftSong=1 for one cycle, step+=1, boxCounter=1 -> BOX_SETUP.
  - BOX_SETUP: two cycles. loadStartAddress=1 on the second cycle, covering the datapath's registered address/colour mux. pixelCount=0 -> BOX_DRAW.
  - BOX_DRAW: loadX=loadY=writeToScreen=1 each cycle.
    - Y field increments 0..BOX_H-1, then X field increments.
    - At X=BOX_W-1, Y=BOX_H-1 -> NEXT_BOX.
    - 3600 cycles per box.
  - NEXT_BOX: boxCounter<12 -> boxCounter+1, BOX_SETUP. boxCounter=12 -> boxCounter=0, SCORE.
  - SCORE: changeScore=1 for one cycle, then addScore=1 for one cycle.
    - If step=SONG_STEPS -> DONE; else -> TICK_WAIT with divider=0.
  - DONE: songDone=1 for one cycle -> IDLE. start still high starts a new song on the next cycle.
- plot:
  - writeDefault|writeToScreen delayed through a PLOT_LAT-stage shift register.
  - Plot pulses trail the final strobe by PLOT_LAT cycles, including into TICK_WAIT, NEXT_BOX and IDLE.
- start is ignored outside IDLE. The divider does not run during drawing; a step period is TICKS_PER_STEP plus draw time.
- Reset asserted mid-operation aborts immediately: no songDone, plot delay line flushed.
- Mutual exclusion: writeDefault and writeToScreen never high in the same cycle; shiftSong never coincides with any write strobe.
- Counter widths: all comparisons against parameter minus 1 are exact, with no overflow. Counters must not wrap past their limit.

Test Plan:
- Reset low mid-BOX_DRAW -> all outputs 0 within the same cycle; after release, busy=0, and plot stays 0 for PLOT_LAT+5 cycles.
- start pulse, TICKS_PER_STEP=4, SONG_STEPS=2 -> 43200 writeDefault cycles, last gridCounter=16'hEFB3; then shiftSong exactly 2 times; songDone once; busy returns 0.
- One step -> boxCounter visits 1..12 in order; 3600 writeToScreen cycles per box; pixelCount last value 15'h1DBB; loadStartAddress asserted 12 times.
- Count plot pulses per step = 43200 (first step only) + 43200; each plot rises exactly 3 cycles after its strobe.
- changeScore then addScore on consecutive cycles, once per step, after boxCounter returns to 0 and before the next shiftSong.
- start held high through DONE -> new song; CLEAR begins the cycle after songDone; start toggled during TICK_WAIT has no effect.

Source files
------------

// File: rtl/song_draw_control.sv
// song_draw_control: sequences grid clear, per-step song shift, 12-box redraw and scoring, plus VGA plot enable
//   clock, reset (async active-low), start (level, sampled in IDLE)
//   shiftSong, loadDefault, writeDefault, loadStartAddress, loadX, loadY, writeToScreen,
//   changeScore, addScore, songDone : datapath strobes
//   gridCounter {X,Y} clear position, boxCounter 1..12 (0 = none), pixelCount {X,Y} box offset
//   plot : write enable aligned to the datapath's registered pixel outputs, busy : not IDLE
module song_draw_control #(
    parameter int TICKS_PER_STEP = 833334,
    parameter int SONG_STEPS     = 112,
    parameter int GRID_W         = 240,
    parameter int GRID_H         = 180,
    parameter int BOX_W          = 60,
    parameter int BOX_H          = 60,
    parameter int PLOT_LAT       = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        shiftSong,
    output logic        loadDefault,
    output logic        writeDefault,
    output logic        loadStartAddress,
    output logic        loadX,
    output logic        loadY,
    output logic        writeToScreen,
    output logic        changeScore,
    output logic        addScore,
    output logic        songDone,
    output logic [15:0] gridCounter,
    output logic [3:0]  boxCounter,
    output logic [14:0] pixelCount,
    output logic        plot,
    output logic        busy
);
    localparam int DIV_W  = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int STEP_W = $clog2(SONG_STEPS + 1);
    typedef enum logic [3:0] {
        IDLE, CLEAR, TICK_WAIT, SHIFT, SETUP_A, SETUP_B,
        BOX_DRAW, NEXT_BOX, SCORE_CHG, SCORE_ADD, DONE
    } state_t;
    state_t state, next_state;
    logic [7:0]          grid_x, grid_y, pix_x;
    logic [6:0]          pix_y;
    logic [3:0]          box;
    logic [DIV_W-1:0]    divider;
    logic [STEP_W-1:0]   step;
    logic [PLOT_LAT-1:0] plot_dly;
    logic grid_y_end, grid_end, pix_y_end, pix_end, tick_end, last_box, last_step;
    assign grid_y_end  = grid_y == 8'(GRID_H - 1);
    assign grid_end    = grid_y_end && grid_x == 8'(GRID_W - 1);
    assign pix_y_end   = pix_y == 7'(BOX_H - 1);
    assign pix_end     = pix_y_end && pix_x == 8'(BOX_W - 1);
    assign tick_end    = divider == DIV_W'(TICKS_PER_STEP - 1);
    assign last_box    = box == 4'd12;
    assign last_step   = step == STEP_W'(SONG_STEPS);
    assign gridCounter = {grid_x, grid_y};
    assign pixelCount  = {pix_x, pix_y};
    assign boxCounter  = box;
    assign loadY       = loadX;
    assign plot        = plot_dly[PLOT_LAT-1];
    always_comb begin
        next_state       = state;
        shiftSong        = 1'b0;
        loadDefault      = 1'b0;
        writeDefault     = 1'b0;
        loadStartAddress = 1'b0;
        loadX            = 1'b0;
        writeToScreen    = 1'b0;
        changeScore      = 1'b0;
        addScore         = 1'b0;
        songDone         = 1'b0;
        busy             = 1'b1;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                next_state = start ? CLEAR : IDLE;
            end
            CLEAR: begin
                loadDefault  = 1'b1;
                writeDefault = 1'b1;
                next_state   = grid_end ? TICK_WAIT : CLEAR;
            end
            TICK_WAIT: next_state = tick_end ? SHIFT : TICK_WAIT;
            SHIFT: begin
                shiftSong  = 1'b1;
                next_state = SETUP_A;
            end
            SETUP_A: next_state = SETUP_B;
            // second setup cycle: the datapath's address/colour mux is registered
            SETUP_B: begin
                loadStartAddress = 1'b1;
                next_state       = BOX_DRAW;
            end
            BOX_DRAW: begin
                loadX         = 1'b1;
                writeToScreen = 1'b1;
                next_state    = pix_end ? NEXT_BOX : BOX_DRAW;
            end
            NEXT_BOX: next_state = last_box ? SCORE_CHG : SETUP_A;
            SCORE_CHG: begin
                changeScore = 1'b1;
                next_state  = SCORE_ADD;
            end
            SCORE_ADD: begin
                addScore   = 1'b1;
                next_state = last_step ? DONE : TICK_WAIT;
            end
            // a start still held here launches the next song immediately
            DONE: begin
                songDone   = 1'b1;
                next_state = start ? CLEAR : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grid_x   <= '0;
            grid_y   <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            box      <= '0;
            divider  <= '0;
            step     <= '0;
            plot_dly <= '0;
        end else begin
            state    <= next_state;
            plot_dly <= (plot_dly << 1) | PLOT_LAT'(writeDefault | writeToScreen);
            if (next_state == CLEAR && state != CLEAR) begin
                grid_x <= '0;
                grid_y <= '0;
            end else if (state == CLEAR && !grid_end) begin
                grid_y <= grid_y_end ? 8'd0 : grid_y + 8'd1;
                grid_x <= grid_y_end ? grid_x + 8'd1 : grid_x;
            end
            if (next_state == TICK_WAIT && state != TICK_WAIT)
                divider <= '0;
            else if (state == TICK_WAIT && !tick_end)
                divider <= divider + DIV_W'(1);
            if (state == CLEAR && grid_end)
                step <= '0;
            else if (state == SHIFT)
                step <= step + STEP_W'(1);
            if (state == SHIFT)
                box <= 4'd1;
            else if (state == NEXT_BOX)
                box <= last_box ? 4'd0 : box + 4'd1;
            if (state == SETUP_B) begin
                pix_x <= '0;
                pix_y <= '0;
            end else if (state == BOX_DRAW && !pix_end) begin
                pix_y <= pix_y_end ? 7'd0 : pix_y + 7'd1;
                pix_x <= pix_y_end ? pix_x + 8'd1 : pix_x;
            end
        end
    end
endmodule
